instr_fetch_responder: RTL and testbench
========================================

// Module: instr_fetch_responder
// PURPOSE
//  Responder end of the instruction-fetch interface: accepts a byte address from the PC/fetch
//  initiator over a valid/ready request channel and returns the addressed 32-bit instruction
//  over a valid/ready response channel after a programmable wait.
//  Holds a small word-addressed instruction store, loaded through a dedicated write port.
//  Sits between the PC and the decode stage of the training MIPS datapath.
// PARAMETERS
//  ADDR_W      4   request/write byte-address width
//  DATA_W      32  instruction width
//  MEM_WORDS   4   store depth in words (word index = addr >> 2)
//  WAIT_CYCLES 1   extra cycles spent in WAIT before responding (0..15)
// PORTS
//  clk         in   1        rising-edge clock
//  reset_n     in   1        asynchronous, active-low reset
//  req_valid   in   1        fetch request present
//  req_addr    in   ADDR_W   fetch byte address (from PC)
//  req_ready   out  1        responder can accept a request
//  rsp_valid   out  1        response present
//  rsp_data    out  DATA_W   fetched instruction
//  rsp_err     out  1        misaligned or out-of-range fetch
//  rsp_ready   in   1        consumer accepts response
//  wr_en       in   1        store write strobe
//  wr_addr     in   ADDR_W   store write byte address
//  wr_data     in   DATA_W   store write data
//  busy        out  1        1 in WAIT or RESP
//  fetch_count out  8        completed responses, wraps 255 -> 0
// BEHAVIOUR
//  Reset (reset_n=0, asynchronous): state=IDLE; rsp_valid=0, rsp_data=0, rsp_err=0,
//   busy=0, fetch_count=0; every store word cleared to 0. req_ready is 1 after reset.
//  FSM: IDLE -> (req_valid & req_ready) -> WAIT if WAIT_CYCLES>0, else RESP.
//   WAIT: counter loaded with WAIT_CYCLES on accept and decremented each cycle;
//   WAIT -> RESP when the counter reaches 1.
//   RESP -> (rsp_valid & rsp_ready) -> IDLE.
//  req_ready=1 only in IDLE. req_addr is latched at accept and is ignored afterwards.
//  Latency: accept edge to rsp_valid high = WAIT_CYCLES+1 cycles.
//  Back-to-back: no accept in the response-handshake cycle; the next accept is earliest
//   one cycle later, in IDLE.
//  rsp_data/rsp_err are registered on entry to RESP and held stable while rsp_valid=1
//   and rsp_ready=0. rsp_valid deasserts the cycle after the handshake.
//   rsp_data returns to 0 in IDLE.
//  Error: latched addr[1:0]!=0 or (addr>>2)>=MEM_WORDS -> rsp_err=1, rsp_data=0.
//   The response still completes normally and still counts.
//  Write port: wr_en writes mem[wr_addr>>2] at the clock edge, in any state.
//   Misaligned or out-of-range writes are silently dropped.
//   Write and RESP-entry to the same word in the same cycle: response carries the OLD word.
//   The new value is visible to later fetches.
//  fetch_count increments by 1 on each response handshake; 8-bit wrap-around.
//  Reset asserted mid-transaction (WAIT or RESP): transaction is dropped, no response,
//   store cleared. Next request is accepted normally after reset_n rises.
// TESTING
//  T1 reset: reset_n=0 mid-WAIT -> immediately rsp_valid=0, busy=0, fetch_count=0,
//   req_ready=1 after release.
//  T2 basic fetch: load mem[1]=32'h2002_0005; req addr=4, rsp_ready=1 -> rsp_valid 2 cycles
//   after accept, rsp_data=32'h2002_0005, rsp_err=0, fetch_count=1.
//  T3 backpressure: rsp_ready=0 for 5 cycles -> rsp_valid, rsp_data and rsp_err constant,
//   req_ready=0; handshake on cycle 6 -> IDLE next cycle.
//  T4 errors: req addr=4'h6 -> rsp_err=1, rsp_data=0; write to 4'h3 -> store unchanged.
//  T5 collision: write mem[2]=32'hDEAD_BEEF on the RESP-entry edge of a fetch of addr 8
//   -> response shows the old word; refetch shows 32'hDEAD_BEEF.
//  T6 PC sweep: addresses 0,4,8,12 repeated 64 times (256 fetches) -> data matches store
//   for every fetch, fetch_count wraps to 0; repeat with WAIT_CYCLES=0 -> latency 1.

Source files
------------

// File: rtl/instr_fetch_responder.sv
// Instruction-fetch responder: valid/ready request in, registered 32-bit instruction out after a
// programmable wait, backed by a small word-addressed store with its own write port.
module instr_fetch_responder #(
  parameter int unsigned ADDR_W      = 4,
  parameter int unsigned DATA_W      = 32,
  parameter int unsigned MEM_WORDS   = 4,
  parameter int unsigned WAIT_CYCLES = 1
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              req_valid,
  input  logic [ADDR_W-1:0] req_addr,
  output logic              req_ready,
  output logic              rsp_valid,
  output logic [DATA_W-1:0] rsp_data,
  output logic              rsp_err,
  input  logic              rsp_ready,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  output logic              busy,
  output logic [7:0]        fetch_count
);

  typedef enum logic [1:0] {StIdle, StWait, StResp} state_e;

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [3:0]        cnt_q, cnt_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic              err_q, err_d;
  logic [7:0]        fcnt_q, fcnt_d;
  logic [DATA_W-1:0] mem_q [MEM_WORDS];
  logic [DATA_W-1:0] mem_d [MEM_WORDS];

  logic [ADDR_W-1:0] lk_addr;
  logic [31:0]       lk_idx;
  logic              lk_err;
  logic [DATA_W-1:0] lk_word;
  logic [31:0]       wr_idx;
  logic              wr_ok;
  logic              enter_resp;

  // With no wait state the lookup happens on the accept edge, so use the live request address.
  assign lk_addr = (state_q == StIdle) ? req_addr : addr_q;
  assign lk_idx  = 32'(lk_addr >> 2);
  assign lk_err  = (lk_addr[1:0] != 2'b00) || (lk_idx >= MEM_WORDS);

  always_comb begin
    lk_word = '0;
    for (int unsigned i = 0; i < MEM_WORDS; i++) begin
      if (lk_idx == i) lk_word = mem_q[i];
    end
  end

  assign wr_idx = 32'(wr_addr >> 2);
  assign wr_ok  = wr_en && (wr_addr[1:0] == 2'b00) && (wr_idx < MEM_WORDS);

  // Reads above see mem_q, so a same-edge write leaves the response with the old word.
  always_comb begin
    for (int unsigned i = 0; i < MEM_WORDS; i++) begin
      mem_d[i] = mem_q[i];
      if (wr_ok && (wr_idx == i)) mem_d[i] = wr_data;
    end
  end

  always_comb begin
    state_d    = state_q;
    addr_d     = addr_q;
    cnt_d      = cnt_q;
    data_d     = data_q;
    err_d      = err_q;
    fcnt_d     = fcnt_q;
    enter_resp = 1'b0;
    case (state_q)
      StIdle: begin
        if (req_valid) begin
          addr_d = req_addr;
          if (WAIT_CYCLES == 0) begin
            state_d    = StResp;
            enter_resp = 1'b1;
          end else begin
            state_d = StWait;
            cnt_d   = 4'(WAIT_CYCLES);
          end
        end
      end
      StWait: begin
        cnt_d = cnt_q - 4'd1;
        if (cnt_q <= 4'd1) begin
          state_d    = StResp;
          enter_resp = 1'b1;
        end
      end
      StResp: begin
        if (rsp_ready) begin
          state_d = StIdle;
          data_d  = '0;
          err_d   = 1'b0;
          fcnt_d  = fcnt_q + 8'd1;
        end
      end
      default: state_d = StIdle;
    endcase
    if (enter_resp) begin
      err_d  = lk_err;
      data_d = lk_err ? '0 : lk_word;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= StIdle;
      addr_q  <= '0;
      cnt_q   <= '0;
      data_q  <= '0;
      err_q   <= 1'b0;
      fcnt_q  <= '0;
      for (int unsigned i = 0; i < MEM_WORDS; i++) mem_q[i] <= '0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      cnt_q   <= cnt_d;
      data_q  <= data_d;
      err_q   <= err_d;
      fcnt_q  <= fcnt_d;
      for (int unsigned i = 0; i < MEM_WORDS; i++) mem_q[i] <= mem_d[i];
    end
  end

  assign req_ready   = (state_q == StIdle);
  assign rsp_valid   = (state_q == StResp);
  assign busy        = (state_q != StIdle);
  assign rsp_data    = data_q;
  assign rsp_err     = err_q;
  assign fetch_count = fcnt_q;

endmodule

// File: tb/tb_instr_fetch_responder.sv
// Directed bench for instr_fetch_responder: one instance with one wait cycle, one with none.
module tb_instr_fetch_responder;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        rv   [2];
  logic [3:0]  ra   [2];
  logic        rr   [2];
  logic        rsv  [2];
  logic [31:0] rd   [2];
  logic        re   [2];
  logic        rrdy [2];
  logic        bsy  [2];
  logic [7:0]  fc   [2];
  logic        wr_en;
  logic [3:0]  wr_addr;
  logic [31:0] wr_data;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  instr_fetch_responder #(.ADDR_W(4), .DATA_W(32), .MEM_WORDS(4), .WAIT_CYCLES(1)) dut (
    .clk(clk), .reset_n(reset_n),
    .req_valid(rv[0]), .req_addr(ra[0]), .req_ready(rr[0]),
    .rsp_valid(rsv[0]), .rsp_data(rd[0]), .rsp_err(re[0]), .rsp_ready(rrdy[0]),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .busy(bsy[0]), .fetch_count(fc[0])
  );

  instr_fetch_responder #(.ADDR_W(4), .DATA_W(32), .MEM_WORDS(4), .WAIT_CYCLES(0)) dut0 (
    .clk(clk), .reset_n(reset_n),
    .req_valid(rv[1]), .req_addr(ra[1]), .req_ready(rr[1]),
    .rsp_valid(rsv[1]), .rsp_data(rd[1]), .rsp_err(re[1]), .rsp_ready(rrdy[1]),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .busy(bsy[1]), .fetch_count(fc[1])
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h", tag, got, exp);
    end
  endtask

  // All tasks start and end 1 time unit after a rising edge.
  task automatic write_word(input logic [3:0] a, input logic [31:0] d);
    wr_en = 1'b1; wr_addr = a; wr_data = d;
    @(posedge clk); #1;
    wr_en = 1'b0;
  endtask

  // Present a request across one edge (the accept edge), then scramble the address.
  task automatic send(input int s, input logic [3:0] a);
    rv[s] = 1'b1; ra[s] = a;
    @(posedge clk); #1;
    rv[s] = 1'b0; ra[s] = ~a;
  endtask

  // Latency counts the accept edge as 1.
  task automatic wait_rsp(input int s, output int lat);
    lat = 1;
    while (!rsv[s] && lat < 20) begin
      @(posedge clk); #1;
      lat++;
    end
    if (!rsv[s]) check("rsp_timeout", 32'(rsv[s]), 32'd1);
  endtask

  task automatic fetch(input int s, input logic [3:0] a,
                       output logic [31:0] d, output logic e, output int lat);
    rrdy[s] = 1'b1;
    send(s, a);
    wait_rsp(s, lat);
    d = rd[s]; e = re[s];
    @(posedge clk); #1;
  endtask

  logic [31:0] d, sweep_mem [4];
  logic        e;
  int          lat;
  logic [3:0]  a;

  initial begin
    reset_n = 1'b0;
    wr_en = 1'b0; wr_addr = '0; wr_data = '0;
    for (int i = 0; i < 2; i++) begin
      rv[i] = 1'b0; ra[i] = '0; rrdy[i] = 1'b1;
    end
    repeat (2) @(posedge clk); #1;
    check("rst_rsp_valid", 32'(rsv[0]), 32'd0);
    check("rst_rsp_data", rd[0], 32'd0);
    check("rst_busy", 32'(bsy[0]), 32'd0);
    check("rst_fetch_count", 32'(fc[0]), 32'd0);
    reset_n = 1'b1;
    @(posedge clk); #1;
    check("rst_req_ready", 32'(rr[0]), 32'd1);

    // Basic fetch
    write_word(4'h4, 32'h2002_0005);
    fetch(0, 4'h4, d, e, lat);
    check("basic_latency", lat, 32'd2);
    check("basic_data", d, 32'h2002_0005);
    check("basic_err", 32'(e), 32'd0);
    check("basic_fetch_count", 32'(fc[0]), 32'd1);
    check("idle_rsp_valid", 32'(rsv[0]), 32'd0);
    check("idle_rsp_data", rd[0], 32'd0);

    // Backpressure, then a request held through the handshake cycle
    rrdy[0] = 1'b0;
    send(0, 4'h4);
    wait_rsp(0, lat);
    check("bp_latency", lat, 32'd2);
    for (int i = 0; i < 5; i++) begin
      check("bp_rsp_valid", 32'(rsv[0]), 32'd1);
      check("bp_rsp_data", rd[0], 32'h2002_0005);
      check("bp_rsp_err", 32'(re[0]), 32'd0);
      check("bp_req_ready", 32'(rr[0]), 32'd0);
      @(posedge clk); #1;
    end
    check("bp_hold_valid", 32'(rsv[0]), 32'd1);
    rv[0] = 1'b1; ra[0] = 4'h4; rrdy[0] = 1'b1;
    @(posedge clk); #1;
    check("hs_rsp_valid", 32'(rsv[0]), 32'd0);
    check("hs_no_accept_busy", 32'(bsy[0]), 32'd0);
    check("hs_req_ready", 32'(rr[0]), 32'd1);
    check("hs_fetch_count", 32'(fc[0]), 32'd2);
    send(0, 4'h4);
    wait_rsp(0, lat);
    check("b2b_latency", lat, 32'd2);
    check("b2b_data", rd[0], 32'h2002_0005);
    @(posedge clk); #1;
    check("b2b_fetch_count", 32'(fc[0]), 32'd3);

    // Errors and dropped misaligned write
    write_word(4'h0, 32'h1111_0000);
    write_word(4'h3, 32'hFFFF_FFFF);
    fetch(0, 4'h0, d, e, lat);
    check("misal_wr_word0", d, 32'h1111_0000);
    check("misal_wr_err", 32'(e), 32'd0);
    fetch(0, 4'h4, d, e, lat);
    check("misal_wr_word1", d, 32'h2002_0005);
    fetch(0, 4'h6, d, e, lat);
    check("err_data", d, 32'd0);
    check("err_flag", 32'(e), 32'd1);
    check("err_fetch_count", 32'(fc[0]), 32'd6);

    // Write colliding with RESP entry
    write_word(4'h8, 32'h8C01_0008);
    send(0, 4'h8);
    wr_en = 1'b1; wr_addr = 4'h8; wr_data = 32'hDEAD_BEEF;
    wait_rsp(0, lat);
    wr_en = 1'b0;
    check("coll_old_word", rd[0], 32'h8C01_0008);
    @(posedge clk); #1;
    fetch(0, 4'h8, d, e, lat);
    check("coll_new_word", d, 32'hDEAD_BEEF);
    check("coll_fetch_count", 32'(fc[0]), 32'd8);

    // Reset mid-WAIT
    send(0, 4'h4);
    check("wait_busy", 32'(bsy[0]), 32'd1);
    reset_n = 1'b0;
    #1;
    check("midrst_rsp_valid", 32'(rsv[0]), 32'd0);
    check("midrst_busy", 32'(bsy[0]), 32'd0);
    check("midrst_fetch_count", 32'(fc[0]), 32'd0);
    @(posedge clk); #1;
    reset_n = 1'b1;
    repeat (3) @(posedge clk); #1;
    check("postrst_no_rsp", 32'(rsv[0]), 32'd0);
    check("postrst_req_ready", 32'(rr[0]), 32'd1);
    fetch(1, 4'h4, d, e, lat);
    check("postrst_store_cleared", d, 32'd0);
    check("postrst_lat0", lat, 32'd1);
    check("postrst_fc_w0", 32'(fc[1]), 32'd1);

    // PC sweep on both instances
    sweep_mem[0] = 32'h2008_0001;
    sweep_mem[1] = 32'h8D09_0004;
    sweep_mem[2] = 32'h012A_5820;
    sweep_mem[3] = 32'h1000_FFFC;
    for (int i = 0; i < 4; i++) write_word(4'(i * 4), sweep_mem[i]);
    for (int k = 0; k < 256; k++) begin
      a = 4'((k % 4) * 4);
      fetch(0, a, d, e, lat);
      check("sweep_data", d, sweep_mem[k % 4]);
      check("sweep_latency", lat, 32'd2);
    end
    check("sweep_wrap_count", 32'(fc[0]), 32'd0);
    for (int k = 0; k < 256; k++) begin
      a = 4'((k % 4) * 4);
      fetch(1, a, d, e, lat);
      check("sweep0_data", d, sweep_mem[k % 4]);
      check("sweep0_latency", lat, 32'd1);
    end
    check("sweep0_wrap_count", 32'(fc[1]), 32'd1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
